// File: rtl/sccb_slave_resp_if.sv
// Register-bus bundle between sccb_slave_resp and a local register file.
//
// Handshake: there is no valid/ready pair on this bus. reg_wr_o and reg_rd_o
// are single-cycle strobes that are never back-pressured. reg_addr_o and
// reg_wdata_o are valid in the strobe cycle. The register file must present
// reg_rdata_i on the cycle after reg_rd_o, and the responder samples it at
// the end of that cycle. busy_o is a level, high from START to STOP.
// dbg_state exposes the responder FSM state for checkers.
interface sccb_slave_resp_if;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [15:0] reg_addr_o;
  logic [7:0]  reg_wdata_o;
  logic [7:0]  reg_rdata_i;
  logic        busy_o;
  logic [3:0]  dbg_state;

  modport master (
    output reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o, busy_o, dbg_state,
    input  reg_rdata_i
  );

  modport slave (
    input  reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o, busy_o, dbg_state,
    output reg_rdata_i
  );
endinterface

// File: rtl/sccb_slave_resp.sv
// OV5640-style SCCB/I2C register-port responder.
// Decodes writes (DEV, AH, AL, data...) and random reads (DEV, AH, AL,
// repeated START, DEV|1, data...) into single-cycle register-bus strobes.
// Optional macro SCCB_AUTO_INC_EN: auto-incrementing address, burst writes
// and burst reads. Without it the address is fixed and bursts are refused.
module sccb_slave_resp #(
  parameter logic [7:0] DEVID    = 8'h78,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              iic_scl,
  inout  wire               iic_sda,
  sccb_slave_resp_if.master rb
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WD, ACK_WD, RD, MACK, NAK_WAIT
  } state_t;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
  logic [CW-1:0] cnt_q [2];

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  ah_q, ah_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] raddr_q, raddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        sda_oe_q, sda_oe_d;
  logic        ph_q, ph_d;
  logic        dir_q, dir_d;
  logic        mack_q, mack_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        ld_q;
`ifndef SCCB_AUTO_INC_EN
  logic        first_q, first_d;
`endif

  logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  = filt_q[1] & ~prev_q[1];
  assign scl_fall  = ~filt_q[1] & prev_q[1];
  assign start_det = prev_q[0] & ~filt_q[0] & filt_q[1] & prev_q[1];
  assign stop_det  = ~prev_q[0] & filt_q[0] & filt_q[1] & prev_q[1];
  assign byte_in   = {sh_q[6:0], sda_f};

  // Open-drain: only ever pull low or release.
  assign iic_sda = sda_oe_q ? 1'b0 : 1'bz;

  assign rb.reg_wr_o    = wr_q;
  assign rb.reg_rd_o    = rd_q;
  assign rb.reg_addr_o  = raddr_q;
  assign rb.reg_wdata_o = wdata_q;
  assign rb.busy_o      = (state_q != IDLE);
  assign rb.dbg_state   = state_q;

  // Synchronise SCL/SDA, then accept a level change only after FILT_LEN
  // consecutive differing samples. Idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {iic_scl, iic_sda};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      ah_q     <= '0;
      addr_q   <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
      sda_oe_q <= 1'b0;
      ph_q     <= 1'b0;
      dir_q    <= 1'b0;
      mack_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ld_q     <= 1'b0;
`ifndef SCCB_AUTO_INC_EN
      first_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      ah_q     <= ah_d;
      addr_q   <= addr_d;
      raddr_q  <= raddr_d;
      wdata_q  <= wdata_d;
      sda_oe_q <= sda_oe_d;
      ph_q     <= ph_d;
      dir_q    <= dir_d;
      mack_q   <= mack_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ld_q     <= rd_q;
`ifndef SCCB_AUTO_INC_EN
      first_q  <= first_d;
`endif
    end
  end

  // Next-state and datapath decode; START/STOP override everything.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    ah_d     = ah_q;
    addr_d   = addr_q;
    raddr_d  = raddr_q;
    wdata_d  = wdata_q;
    sda_oe_d = sda_oe_q;
    ph_d     = ph_q;
    dir_d    = dir_q;
    mack_d   = mack_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
`ifndef SCCB_AUTO_INC_EN
    first_d  = first_q;
`endif
    // Read data arrives the cycle after the read strobe; put its MSB on SDA.
    if (ld_q) begin
      sh_d     = rb.reg_rdata_i;
      sda_oe_d = ~rb.reg_rdata_i[7];
    end
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d  = DEV;
      bit_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        DEV, AH, AL, WD: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              ph_d = 1'b0;
              case (state_q)
                DEV: begin
                  if (byte_in == DEVID) begin
                    state_d = ACK_DEV;
                    dir_d   = 1'b0;
                  end else if (byte_in == (DEVID | 8'h01)) begin
                    state_d = ACK_DEV;
                    dir_d   = 1'b1;
                  end else begin
                    state_d = NAK_WAIT;
                  end
                end
                AH: begin
                  ah_d    = byte_in;
                  state_d = ACK_AH;
                end
                AL: begin
                  addr_d  = {ah_q, byte_in};
                  state_d = ACK_AL;
                end
                default: begin
`ifdef SCCB_AUTO_INC_EN
                  wr_d    = 1'b1;
                  raddr_d = addr_q;
                  wdata_d = byte_in;
                  addr_d  = addr_q + 16'd1;
                  state_d = ACK_WD;
`else
                  if (first_q) begin
                    wr_d    = 1'b1;
                    raddr_d = addr_q;
                    wdata_d = byte_in;
                    first_d = 1'b0;
                    state_d = ACK_WD;
                  end else begin
                    state_d = NAK_WAIT;
                  end
`endif
                end
              endcase
            end
          end
        end
        ACK_DEV, ACK_AH, ACK_AL, ACK_WD: begin
          // First falling edge: pull low. Second one (after 9th clock): release.
          if (scl_fall) begin
            if (!ph_q) begin
              sda_oe_d = 1'b1;
              ph_d     = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bit_d    = '0;
              case (state_q)
                ACK_DEV: begin
                  if (dir_q) begin
                    state_d = RD;
                    rd_d    = 1'b1;
                    raddr_d = addr_q;
                  end else begin
                    state_d = AH;
                  end
                end
                ACK_AH:  state_d = AL;
                ACK_AL: begin
                  state_d = WD;
`ifndef SCCB_AUTO_INC_EN
                  first_d = 1'b1;
`endif
                end
                default: state_d = WD;
              endcase
            end
          end
        end
        RD: begin
          if (scl_fall) begin
            if (bit_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = MACK;
              ph_d     = 1'b0;
              bit_d    = '0;
            end else begin
              sh_d     = {sh_q[6:0], 1'b1};
              sda_oe_d = ~sh_q[6];
              bit_d    = bit_q + 3'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            mack_d = sda_f;
            ph_d   = 1'b1;
          end else if (scl_fall && ph_q) begin
            if (mack_q) begin
              state_d = NAK_WAIT;
            end else begin
              state_d = RD;
              bit_d   = '0;
`ifdef SCCB_AUTO_INC_EN
              addr_d  = addr_q + 16'd1;
              raddr_d = addr_q + 16'd1;
              rd_d    = 1'b1;
`else
              sh_d     = 8'hFF;
              sda_oe_d = 1'b0;
`endif
            end
          end
        end
        IDLE, NAK_WAIT: ;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
